// File: rtl/timer_display_pkg.sv
// Shared types and constants for the countdown timer display path.
// Holds the FSM state enum, BCD digit type, and the seconds clamp helper.
package timer_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    COMMIT
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam logic [5:0] SEC_MAX     = 6'd59;
  localparam logic [2:0] CONV_CYCLES = 3'd6;

  // Out-of-range seconds from the timer are shown as 59.
  function automatic logic [5:0] clamp_sec(input logic [5:0] s);
    return (s > SEC_MAX) ? SEC_MAX : s;
  endfunction

endpackage

// File: rtl/timer_display_bin2bcd6.sv
// Serial 6-bit binary to two-digit BCD converter, one bit per cycle.
// Ports: clk, reset, start (load bin), bin[5:0], done (1-cycle pulse), tens, ones.
module bin2bcd6
  import timer_display_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] bin,
  output logic       done,
  output bcd_t       tens,
  output bcd_t       ones
);

  logic [5:0] sh;
  logic [7:0] bcd;
  logic [7:0] adj;
  logic [2:0] cnt;
  logic       busy;

  // Add-3 on any nibble >= 5 before the shift keeps each digit in BCD.
  always_comb begin
    adj = bcd;
    if (bcd[3:0] >= 4'd5) adj[3:0] = bcd[3:0] + 4'd3;
    if (bcd[7:4] >= 4'd5) adj[7:4] = bcd[7:4] + 4'd3;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh   <= '0;
      bcd  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sh   <= bin;
        bcd  <= '0;
        cnt  <= CONV_CYCLES;
        busy <= 1'b1;
      end else if (busy) begin
        {bcd, sh} <= {adj[6:0], sh, 1'b0};
        cnt       <= cnt - 3'd1;
        if (cnt == 3'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign tens = bcd[7:4];
  assign ones = bcd[3:0];

endmodule

// File: rtl/timer_display.sv
// Frame-synchronous snapshot, BCD conversion and blink control for a timer.
// Ports: clk, reset, minute, second, to, frame_tick -> digits, valid, blink_on, expired, overrun.
module timer_display
  import timer_display_pkg::*;
#(
  parameter int BLINK_FRAMES = 16,
  parameter int LOW_TIME_SEC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] minute,
  input  logic [5:0] second,
  input  logic       to,
  input  logic       frame_tick,
  output bcd_t       digit_m,
  output bcd_t       digit_s10,
  output bcd_t       digit_s1,
  output logic       valid,
  output logic       blink_on,
  output logic       expired,
  output logic       overrun
);

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);

  state_t        state;
  logic [3:0]    snap_min;
  logic [5:0]    snap_sec;
  logic          snap_to;
  logic [CW-1:0] blink_cnt;

  logic       start;
  logic       conv_done;
  bcd_t       tens;
  bcd_t       ones;
  logic [7:0] total;
  logic       low_time;
  logic       exp_next;

  // The converter loads on the same edge the snapshot is taken.
  assign start    = (state == IDLE) && frame_tick;
  assign total    = {4'b0, snap_min} * 8'd60 + {2'b0, snap_sec};
  assign low_time = (int'(total) < LOW_TIME_SEC) && !snap_to;
  assign exp_next = expired | snap_to;

  bin2bcd6 u_conv (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (clamp_sec(second)),
    .done  (conv_done),
    .tens  (tens),
    .ones  (ones)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      snap_min  <= '0;
      snap_sec  <= '0;
      snap_to   <= 1'b0;
      blink_cnt <= '0;
      digit_m   <= '0;
      digit_s10 <= '0;
      digit_s1  <= '0;
      valid     <= 1'b0;
      blink_on  <= 1'b1;
      expired   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (frame_tick) begin
            snap_min <= {2'b0, minute};
            snap_sec <= clamp_sec(second);
            snap_to  <= to;
            state    <= CONVERT;
          end
        end
        CONVERT: begin
          if (frame_tick) overrun <= 1'b1;
          if (conv_done) state <= COMMIT;
        end
        COMMIT: begin
          if (frame_tick) overrun <= 1'b1;
          valid   <= 1'b1;
          expired <= exp_next;
          if (exp_next) begin
            digit_m   <= '0;
            digit_s10 <= '0;
            digit_s1  <= '0;
            blink_on  <= 1'b1;
            blink_cnt <= '0;
          end else begin
            digit_m   <= snap_min;
            digit_s10 <= tens;
            digit_s1  <= ones;
            if (low_time) begin
              if (blink_cnt == CNT_LAST) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
              end else begin
                blink_cnt <= blink_cnt + 1'b1;
              end
            end else begin
              blink_cnt <= '0;
              blink_on  <= 1'b1;
            end
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_display.sv
// Scoreboard bench for timer_display: stimulus queues due-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_timer_display;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] minute = '0;
  logic [5:0] second = '0;
  logic       to = 1'b0;
  logic       frame_tick = 1'b0;
  logic [3:0] digit_m;
  logic [3:0] digit_s10;
  logic [3:0] digit_s1;
  logic       valid;
  logic       blink_on;
  logic       expired;
  logic       overrun;

  timer_display #(
    .BLINK_FRAMES (16),
    .LOW_TIME_SEC (10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .minute     (minute),
    .second     (second),
    .to         (to),
    .frame_tick (frame_tick),
    .digit_m    (digit_m),
    .digit_s10  (digit_s10),
    .digit_s1   (digit_s1),
    .valid      (valid),
    .blink_on   (blink_on),
    .expired    (expired),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    string      name;
    logic [3:0] m;
    logic [3:0] t;
    logic [3:0] o;
    logic       v;
    logic       b;
    logic       e;
    logic       ov;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  function automatic void push(input int due, input string name,
                               input logic [3:0] m, input logic [3:0] t,
                               input logic [3:0] o, input logic v,
                               input logic b, input logic e,
                               input logic ov);
    exp_t x;
    x.due = due; x.name = name;
    x.m = m; x.t = t; x.o = o;
    x.v = v; x.b = b; x.e = e; x.ov = ov;
    q.push_back(x);
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        exp_t x;
        x = q.pop_front();
        n_chk++;
        if (x.due != cyc ||
            {digit_m, digit_s10, digit_s1, valid, blink_on, expired, overrun}
            !== {x.m, x.t, x.o, x.v, x.b, x.e, x.ov}) begin
          n_fail++;
          $display("FAIL %s @%0d: got m=%0d s10=%0d s1=%0d v=%0b b=%0b e=%0b ov=%0b, want m=%0d s10=%0d s1=%0d v=%0b b=%0b e=%0b ov=%0b (due %0d)",
                   x.name, cyc, digit_m, digit_s10, digit_s1, valid,
                   blink_on, expired, overrun, x.m, x.t, x.o, x.v,
                   x.b, x.e, x.ov, x.due);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick(input logic [1:0] m, input logic [5:0] s,
                      input logic t);
    minute = m; second = s; to = t;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1;
    push(cyc + 1, name, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  int k;

  initial begin
    @(negedge clk);
    do_reset("reset0");

    k = cyc;
    push(k + 8, "latency_pre", 0, 0, 0, 0, 1, 0, 0);
    push(k + 9, "t2_47", 2, 4, 7, 1, 1, 0, 0);
    tick(2, 47, 0);
    wait_cyc(10);

    k = cyc;
    push(k + 4, "overrun_set", 2, 4, 7, 1, 1, 0, 1);
    push(k + 9, "first_snap", 1, 0, 5, 1, 1, 0, 1);
    push(k + 20, "no_restart", 1, 0, 5, 1, 1, 0, 1);
    tick(1, 5, 0);
    wait_cyc(2);
    tick(3, 30, 0);
    wait_cyc(17);

    do_reset("reset1");
    for (int i = 1; i <= 32; i++) begin
      k = cyc;
      push(k + 9, $sformatf("low_frame%0d", i), 0, 0, 9, 1,
           (i >= 16 && i < 32) ? 1'b0 : 1'b1, 0, 0);
      tick(0, 9, 0);
      wait_cyc(9);
    end

    k = cyc;
    push(k + 9, "clamp63", 1, 5, 9, 1, 1, 0, 0);
    tick(1, 63, 0);
    wait_cyc(10);

    k = cyc;
    push(k + 9, "low_edge10", 0, 1, 0, 1, 1, 0, 0);
    tick(0, 10, 0);
    wait_cyc(10);

    k = cyc;
    push(k + 9, "expire", 0, 0, 0, 1, 1, 1, 0);
    tick(1, 20, 1);
    wait_cyc(10);

    k = cyc;
    push(k + 9, "expire_hold", 0, 0, 0, 1, 1, 1, 0);
    tick(2, 33, 0);
    wait_cyc(10);

    do_reset("reset2");

    k = cyc;
    push(k + 9, "pre_abort", 2, 4, 7, 1, 1, 0, 0);
    tick(2, 47, 0);
    wait_cyc(10);

    k = cyc;
    tick(1, 23, 0);
    wait_cyc(2);
    do_reset("abort_reset");
    k = cyc;
    push(k + 8, "no_commit_a", 0, 0, 0, 0, 1, 0, 0);
    push(k + 14, "no_commit_b", 0, 0, 0, 0, 1, 0, 0);
    wait_cyc(15);

    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d checks pending, want 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
